fpmul_arbiter: RTL and testbench
================================

# fpmul_arbiter

Round-robin arbiter and sequencer that shares one `multiplier32FP` core among `N_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the core's start pulse. It holds operands stable for the whole operation and accumulates the core's transient exception flags. It returns product, flags and requester ID on a single backpressured response channel. It sits between the core and the client datapaths and is the only block allowed to drive the core.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters; legal range is 2 to 16.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester ID.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset; asynchronous, active-low. The core receives the same `rst_n`.
- `req_valid`, in, `N_REQ`: per-requester request valid.
- `req_ready`, out, `N_REQ`: per-requester accept; at most one bit is high in any cycle.
- `req_a`, in, `N_REQ*32`: operand A; requester i uses bits `[32i+31:32i]`.
- `req_b`, in, `N_REQ*32`: operand B, packed the same way as `req_a`.
- `rsp_valid`, out, 1: a response is available.
- `rsp_ready`, in, 1: the consumer accepts the response.
- `rsp_id`, out, `ID_W`: index of the requester that issued the operation.
- `rsp_product`, out, 32: result as produced by the core.
- `rsp_flags`, out, 4: `{nan, infinit, overflow, underflow}`.
- `mul_start_o`, out, 1: core `start_i`.
- `mul_a_o`, out, 32: core `a_i`.
- `mul_b_o`, out, 32: core `b_i`.
- `mul_product_i`, in, 32: core `product_o`.
- `mul_done_i`, in, 1: core `done_o`.
- `mul_nan_i`, `mul_inf_i`, `mul_ovf_i`, `mul_unf_i`, in, 1 each: core exception flags.
- `op_count_o`, out, 16: number of completed response handshakes; wraps modulo 2^16.

## Operation
Core contract the arbiter relies on:
- The core samples `a_i`/`b_i` combinationally in the two cycles after the start cycle. Operands must therefore stay stable from start until done.
- `nan` is valid only in the cycle after start.
- `infinit`, `overflow` and `underflow` are valid only in the second cycle after start.
- `done` pulses for 1 cycle: at start+3 normally, at start+2 on the NaN path. All flags are 0 during the done cycle.
- `start` is ignored unless the core is idle.

State machine (`IDLE`, `ISSUE`, `WAIT`, `RESP`):
- **IDLE**
  - If any `req_valid` is high, select grant g: the first set bit searching upward from `rr_ptr`, wrapping.
  - Assert `req_ready[g]` combinationally in this cycle only.
  - Register `req_a[g]` into `op_a`, `req_b[g]` into `op_b`, and g into `id_q`.
  - Go to ISSUE.
- **ISSUE**
  - `mul_start_o=1` for exactly this cycle.
  - Clear `flags_q` to 0.
  - Go to WAIT.
- **WAIT**
  - Each cycle, OR the four core flags into `flags_q`.
  - When `mul_done_i=1`, capture `mul_product_i` into `prod_q` and go to RESP.
  - The flag OR is also applied in the done cycle; this is harmless because flags are 0 then.
- **RESP**
  - `rsp_valid=1`; `rsp_id`, `rsp_product` and `rsp_flags` are driven from `id_q`, `prod_q` and `flags_q` and stay stable.
  - On `rsp_ready`: set `rr_ptr=(id_q+1) mod N_REQ`, increment `op_count_o`, go to IDLE.

Rules:
- `mul_a_o`/`mul_b_o` are always driven from `op_a`/`op_b`. They change only in the IDLE grant cycle.
- Only one operation is outstanding at a time; no request is accepted outside IDLE.
- Requesters must hold `req_valid` and operands until they see `req_ready`. The arbiter tolerates `req_valid` dropping early; such a request is simply not granted.
- Fairness: a requester that was just served has the lowest priority in the next arbitration. Any requester with valid held high is served within `N_REQ` operations.

## Timing
Reset values:
- state `IDLE`, `rr_ptr=0`.
- `req_ready=0`, `mul_start_o=0`, `rsp_valid=0`.
- `rsp_id`, `rsp_product`, `rsp_flags` = 0.
- `mul_a_o`, `mul_b_o` = 0.
- `op_count_o=0`.

Latency, with acceptance in cycle T:
- Start is asserted at T+1.
- `mul_done_i` arrives at T+4 (T+3 on the NaN path).
- `rsp_valid` rises at T+5 (T+4 on NaN).

Throughput:
- With `rsp_ready` tied high, the next acceptance is at T+6 (T+5 on NaN).
- Stalled `rsp_ready` adds one cycle per stall cycle.

Boundary conditions:
- **Reset mid-operation:** all state returns to reset values in the same cycle, with no response emitted. The core resets simultaneously.
- **Request arriving while the arbiter is in RESP with `rsp_ready=1`:** not accepted before the following cycle, which is IDLE.
- **`mul_done_i` outside WAIT:** ignored.
- **`op_count_o` wrap:** 0xFFFF increments to 0x0000.

## Test plan
1. **Single normal operation.** Requester 0 sends a=0x3FC00000, b=0x40000000. Expect `req_ready[0]` for 1 cycle, start at T+1, and at T+5 `rsp_product=0x40400000`, `rsp_flags=0`, `rsp_id=0`.
2. **NaN path.** Requester 2 sends a=0x7FC00000, b=0x3F800000. Expect `rsp_valid` at T+4, `rsp_product=0x00000000`, `rsp_flags=4'b1000`, `rsp_id=2`.
3. **Overflow and infinity.** Requester 1 sends 0x7F000000 × 0x7F000000: expect `rsp_product=0x7FFFFFFF`, `rsp_flags=4'b0010`. Then 0x7F800000 × 0x3F800000: expect 0x7FFFFFFF with `rsp_flags=4'b0100`.
4. **Contention.** All 4 `req_valid` held high for 5 operations. Expect grant and `rsp_id` order 0,1,2,3,0 and `op_count_o=5`.
5. **Backpressure.** Hold `rsp_ready` low for 10 cycles during RESP. Expect response fields stable, `rsp_valid` held, no `req_ready`, and `mul_start_o` staying 0.
6. **Reset mid-operation.** Assert `rst_n` low at T+2 for 1 cycle. Expect all outputs at reset values immediately. Then a new request yields a correct result with `rsp_id` chosen starting from `rr_ptr=0`.

Source files
------------

// File: rtl/fpmul_arbiter.sv
// Round-robin arbiter/sequencer that time-shares one multiplier32FP core among
// N_REQ requesters and returns product, sticky flags and requester id.
module fpmul_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*32-1:0]   req_a,
  input  logic [N_REQ*32-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_product,
  output logic [3:0]            rsp_flags,
  output logic                  mul_start_o,
  output logic [31:0]           mul_a_o,
  output logic [31:0]           mul_b_o,
  input  logic [31:0]           mul_product_i,
  input  logic                  mul_done_i,
  input  logic                  mul_nan_i,
  input  logic                  mul_inf_i,
  input  logic                  mul_ovf_i,
  input  logic                  mul_unf_i,
  output logic [15:0]           op_count_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q;
  logic [ID_W-1:0] rr_q, id_q;
  logic [31:0]     op_a_q, op_b_q, prod_q;
  logic [3:0]      flags_q;
  logic [15:0]     cnt_q;
  logic            start_q, rsp_vld_q;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;

  // Scan downward in distance from rr_q so the nearest valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      id_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      prod_q    <= '0;
      flags_q   <= '0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      rsp_vld_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: if (gnt_found) begin
          op_a_q  <= req_a[{gnt_idx, 5'd0} +: 32];
          op_b_q  <= req_b[{gnt_idx, 5'd0} +: 32];
          id_q    <= gnt_idx;
          start_q <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: begin
          flags_q <= '0;
          state_q <= WAIT;
        end
        // Core flags are single-cycle pulses, so they are made sticky here.
        WAIT: begin
          flags_q <= flags_q | {mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i};
          if (mul_done_i) begin
            prod_q    <= mul_product_i;
            rsp_vld_q <= 1'b1;
            state_q   <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rr_q      <= (int'(id_q) == N_REQ - 1) ? '0 : id_q + 1'b1;
          cnt_q     <= cnt_q + 16'd1;
          rsp_vld_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_start_o = start_q;
  assign mul_a_o     = op_a_q;
  assign mul_b_o     = op_b_q;
  assign rsp_valid   = rsp_vld_q;
  assign rsp_id      = id_q;
  assign rsp_product = prod_q;
  assign rsp_flags   = flags_q;
  assign op_count_o  = cnt_q;

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Directed bench for fpmul_arbiter with a behavioural multiplier core that
// follows the core's start/flag/done timing contract.
module tb_fpmul_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a = '0, req_b = '0;
  logic            rsp_valid, rsp_ready = 1'b1;
  logic [1:0]      rsp_id;
  logic [31:0]     rsp_product;
  logic [3:0]      rsp_flags;
  logic            mul_start_o;
  logic [31:0]     mul_a_o, mul_b_o, mul_product_i;
  logic            mul_done_i, mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i;
  logic [15:0]     op_count_o;
  logic            inj_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fpmul_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .rsp_flags(rsp_flags),
    .mul_start_o(mul_start_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_product_i(mul_product_i), .mul_done_i(mul_done_i),
    .mul_nan_i(mul_nan_i), .mul_inf_i(mul_inf_i), .mul_ovf_i(mul_ovf_i),
    .mul_unf_i(mul_unf_i), .op_count_o(op_count_o)
  );

  // ---------------- behavioural core ----------------
  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // returns {inf, ovf, unf, product}
  function automatic logic [34:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] m;
    logic [22:0] mant;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {3'b100, s, 31'h7FFFFFFF};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {3'b000, s, 31'h0};
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) begin mant = m[46:24]; e = e + 1; end
    else mant = m[45:23];
    if (e >= 255) return {3'b010, s, 31'h7FFFFFFF};
    if (e <= 0)   return {3'b001, s, 31'h0};
    return {3'b000, s, e[7:0], mant};
  endfunction

  logic [1:0]  ph_q;
  logic        nanp_q;
  logic [31:0] cprod_q, core_prod;
  logic [34:0] fm;
  logic        core_done;

  assign fm = fmul(mul_a_o, mul_b_o);

  always_comb begin
    mul_nan_i = 1'b0; mul_inf_i = 1'b0; mul_ovf_i = 1'b0; mul_unf_i = 1'b0;
    core_done = 1'b0; core_prod = 32'h0;
    case (ph_q)
      2'd1: mul_nan_i = is_nan(mul_a_o) || is_nan(mul_b_o);
      2'd2: if (nanp_q) core_done = 1'b1;
            else {mul_inf_i, mul_ovf_i, mul_unf_i} = fm[34:32];
      2'd3: begin core_done = 1'b1; core_prod = cprod_q; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q <= 2'd0; nanp_q <= 1'b0; cprod_q <= 32'h0;
    end else begin
      case (ph_q)
        2'd0: if (mul_start_o) ph_q <= 2'd1;
        2'd1: begin nanp_q <= mul_nan_i; ph_q <= 2'd2; end
        2'd2: if (nanp_q) ph_q <= 2'd0;
              else begin cprod_q <= fm[31:0]; ph_q <= 2'd3; end
        default: ph_q <= 2'd0;
      endcase
    end
  end

  assign mul_done_i    = core_done | inj_done;
  assign mul_product_i = inj_done ? 32'hDEADBEEF : core_prod;

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Returns just after the edge that ends the grant cycle (T+1).
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       output bit ok);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_valid[i] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  // Leaves time at the negedge of the cycle where rsp_valid is seen; lat=-1 on timeout.
  task automatic wait_rsp(input int lat0, output int lat);
    lat = lat0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rsp_valid) return;
      @(posedge clk); #1;
      lat++;
    end
    lat = -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_checks++;
    if ({req_ready, mul_start_o, rsp_valid} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {req_ready, mul_start_o, rsp_valid});
    end
    n_checks++;
    if ({rsp_id, rsp_product, rsp_flags, mul_a_o, mul_b_o, op_count_o} !== '0) begin
      n_fail++; $display("FAIL reset_data: got id=%h p=%h f=%h a=%h b=%h cnt=%h expected all 0",
                         rsp_id, rsp_product, rsp_flags, mul_a_o, mul_b_o, op_count_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    bit ok; int lat;
    issue(0, 32'h3FC00000, 32'h40000000, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL single_grant: got %0d expected 1", ok); end
    @(negedge clk);
    n_checks++;
    if ({mul_start_o, req_ready} !== 5'b1_0000 || mul_a_o !== 32'h3FC00000 || mul_b_o !== 32'h40000000) begin
      n_fail++; $display("FAIL single_start: got start=%b rdy=%b a=%h b=%h expected 1 0000 3fc00000 40000000",
                         mul_start_o, req_ready, mul_a_o, mul_b_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (mul_start_o !== 1'b0) begin n_fail++; $display("FAIL single_start_pulse: got %b expected 0", mul_start_o); end
    @(posedge clk); #1;
    wait_rsp(3, lat);
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL single_latency: got %0d expected 5", lat); end
    n_checks++;
    if (rsp_product !== 32'h40400000 || rsp_flags !== 4'b0000 || rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL single_rsp: got p=%h f=%b id=%0d expected 40400000 0000 0", rsp_product, rsp_flags, rsp_id);
    end
    @(posedge clk); #1;
    n_checks++;
    if (op_count_o !== 16'd1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_count: got cnt=%0d vld=%b expected 1 0", op_count_o, rsp_valid);
    end
  endtask

  task automatic test_nan();
    bit ok; int lat;
    issue(2, 32'h7FC00000, 32'h3F800000, ok);
    wait_rsp(1, lat);
    n_checks++;
    if (!ok || lat !== 4) begin n_fail++; $display("FAIL nan_latency: got ok=%0d lat=%0d expected 1 4", ok, lat); end
    n_checks++;
    if (rsp_product !== 32'h0 || rsp_flags !== 4'b1000 || rsp_id !== 2'd2) begin
      n_fail++; $display("FAIL nan_rsp: got p=%h f=%b id=%0d expected 00000000 1000 2", rsp_product, rsp_flags, rsp_id);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_exceptions();
    bit ok; int lat;
    issue(1, 32'h7F000000, 32'h7F000000, ok);
    wait_rsp(1, lat);
    n_checks++;
    if (!ok || lat !== 5 || rsp_product !== 32'h7FFFFFFF || rsp_flags !== 4'b0010 || rsp_id !== 2'd1) begin
      n_fail++; $display("FAIL ovf_rsp: got lat=%0d p=%h f=%b id=%0d expected 5 7fffffff 0010 1",
                         lat, rsp_product, rsp_flags, rsp_id);
    end
    @(posedge clk); #1;
    issue(1, 32'h7F800000, 32'h3F800000, ok);
    wait_rsp(1, lat);
    n_checks++;
    if (!ok || lat !== 5 || rsp_product !== 32'h7FFFFFFF || rsp_flags !== 4'b0100 || rsp_id !== 2'd1) begin
      n_fail++; $display("FAIL inf_rsp: got lat=%0d p=%h f=%b id=%0d expected 5 7fffffff 0100 1",
                         lat, rsp_product, rsp_flags, rsp_id);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    logic [31:0] bv [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] pv [4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
    logic [3:0]  exp_rdy;
    int lat, e;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = 32'h40000000;
      req_b[i*32 +: 32] = bv[i];
    end
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      exp_rdy = 4'b0001 << e;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (|req_ready) break;
        @(posedge clk); #1;
      end
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL contention_grant%0d: got %b expected %b", k, req_ready, exp_rdy);
      end
      @(posedge clk); #1;
      if (k == 4) req_valid = '0;
      wait_rsp(1, lat);
      n_checks++;
      if (lat !== 5 || rsp_id !== 2'(e) || rsp_product !== pv[e]) begin
        n_fail++; $display("FAIL contention_rsp%0d: got lat=%0d id=%0d p=%h expected 5 %0d %h",
                           k, lat, rsp_id, rsp_product, e, pv[e]);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (op_count_o !== 16'd5) begin n_fail++; $display("FAIL contention_count: got %0d expected 5", op_count_o); end
  endtask

  task automatic test_backpressure();
    bit ok, bad; int lat;
    rsp_ready = 1'b0;
    issue(3, 32'h3FC00000, 32'h40400000, ok);
    req_a[31:0] = 32'h40000000;
    req_b[31:0] = 32'h40000000;
    req_valid[0] = 1'b1;
    wait_rsp(1, lat);
    n_checks++;
    if (!ok || lat !== 5) begin n_fail++; $display("FAIL bp_latency: got ok=%0d lat=%0d expected 1 5", ok, lat); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      inj_done = (c == 4);
      @(negedge clk);
      bad = (rsp_valid !== 1'b1) || (rsp_product !== 32'h40900000) || (rsp_flags !== 4'b0) ||
            (rsp_id !== 2'd3) || (req_ready !== 4'b0) || (mul_start_o !== 1'b0);
      n_checks++;
      if (bad) begin
        n_fail++; $display("FAIL bp_stall%0d: got v=%b p=%h f=%b id=%0d rdy=%b st=%b expected 1 40900000 0000 3 0000 0",
                           c, rsp_valid, rsp_product, rsp_flags, rsp_id, req_ready, mul_start_o);
      end
    end
    @(posedge clk); #1;
    inj_done = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0 || rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_resp_accept: got rdy=%b v=%b expected 0000 1", req_ready, rsp_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_next_grant: got %b expected 0001", req_ready); end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp(1, lat);
    n_checks++;
    if (lat !== 5 || rsp_id !== 2'd0 || rsp_product !== 32'h40800000) begin
      n_fail++; $display("FAIL bp_next_rsp: got lat=%0d id=%0d p=%h expected 5 0 40800000", lat, rsp_id, rsp_product);
    end
    @(posedge clk); #1;
    n_checks++;
    if (op_count_o !== 16'd7) begin n_fail++; $display("FAIL bp_count: got %0d expected 7", op_count_o); end
  endtask

  task automatic test_reset_mid_op();
    bit ok, seen; int lat;
    issue(3, 32'h40000000, 32'h40000000, ok);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, mul_start_o, rsp_valid} !== 6'b0 || mul_a_o !== 32'h0 || mul_b_o !== 32'h0 ||
        op_count_o !== 16'd0 || rsp_id !== 2'd0 || rsp_product !== 32'h0 || rsp_flags !== 4'b0) begin
      n_fail++; $display("FAIL rst_mid_values: got rdy=%b st=%b v=%b a=%h b=%h cnt=%0d id=%0d p=%h f=%b expected all 0",
                         req_ready, mul_start_o, rsp_valid, mul_a_o, mul_b_o, op_count_o, rsp_id, rsp_product, rsp_flags);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_rsp: got %b expected 0", seen); end
    @(posedge clk); #1;
    req_a[31:0]  = 32'h40000000; req_b[31:0]  = 32'h40400000;
    req_a[95:64] = 32'h3F800000; req_b[95:64] = 32'h3F800000;
    req_valid = 4'b0101;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_mid_grant: got %b expected 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(1, lat);
    n_checks++;
    if (lat !== 5 || rsp_id !== 2'd0 || rsp_product !== 32'h40C00000 || rsp_flags !== 4'b0) begin
      n_fail++; $display("FAIL rst_mid_rsp: got lat=%0d id=%0d p=%h f=%b expected 5 0 40c00000 0000",
                         lat, rsp_id, rsp_product, rsp_flags);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_nan();
    test_exceptions();
    test_contention();
    test_backpressure();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
